fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_queue.sv | 64 ++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch state enum and fetch queue entry type
package cpu_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry fetch FIFO with flush; slot 0 is always the registered head
module fetch_queue
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic         head_valid,
    output fetch_entry_t head_entry
);
    fetch_entry_t e0_q, e0_d, e1_q, e1_d;
    logic         v0_q, v0_d, v1_q, v1_d;

    // Shift organisation: slot 1 is only ever valid when slot 0 is.
    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        if (flush) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else begin
            if (pop) begin
                e0_d = e1_q;
                v0_d = v1_q;
                v1_d = 1'b0;
            end
            if (push) begin
                if (!v0_d) begin
                    e0_d = push_entry;
                    v0_d = 1'b1;
                end else begin
                    e1_d = push_entry;
                    v1_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q <= '0;
            e1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign full       = v1_q;
    assign empty      = !v0_q;
    assign head_valid = v0_q;
    assign head_entry = e0_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM feeding decode through a 2-entry queue
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt / stall_cnt outputs.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    output logic               busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt
`endif
);
    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            q_full, q_empty, push, pop, want_fetch, stall;
    fetch_entry_t    head;

    // halt blocks the fetch in the same cycle so pc freezes where halt was seen
    assign want_fetch = (state_q == ST_RUN) && !halt && !redirect;
    assign pop        = !q_empty && dec_ready && !redirect;
    assign push       = want_fetch && (!q_full || pop);
    assign stall      = want_fetch && q_full && !pop;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~PC_W'(1);
        end else begin
            if (push) begin
                pc_d = pc_q + PC_W'(PC_STEP);
            end
            case (state_q)
                ST_IDLE:   if (start) state_d = ST_RUN;
                ST_RUN:    if (halt) state_d = ST_HALTED;
                ST_HALTED: if (start && !halt) state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_entry ('{instr: imem_instr, pc: pc_q}),
        .pop        (pop),
        .full       (q_full),
        .empty      (q_empty),
        .head_valid (dec_valid),
        .head_entry (head)
    );

    assign imem_pc   = pc_q;
    assign dec_instr = head.instr;
    assign dec_pc    = head.pc;
    assign busy      = (state_q == ST_RUN);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (push && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
        if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-level model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, halt, redirect, dec_ready;
    logic [15:0] redirect_pc, imem_pc, dec_pc;
    logic [31:0] imem_instr, dec_instr;
    logic        dec_valid, busy;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt, stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [15:0] a);
        return {a ^ 16'hC0DE, a + 16'h1111};
    endfunction

    assign imem_instr = instr_at(imem_pc);

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_pc     (imem_pc),
        .imem_instr  (imem_instr),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .busy        (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
    } ent_t;

    localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

    ent_t        mq[$];
    ent_t        mseen[$];
    logic [15:0] m_pc;
    int          m_state, m_fetch, m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 16'h0000;
        m_state = M_IDLE;
        m_fetch = 0;
        m_stall = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_next();
        bit do_pop, can_fetch;
        if (redirect) begin
            mq.delete();
            m_pc = {redirect_pc[15:1], 1'b0};
        end else begin
            do_pop = (mq.size() > 0) && dec_ready;
            can_fetch = (m_state == M_RUN) && !halt;
            if (do_pop) mseen.push_back(mq.pop_front());
            if (can_fetch && mq.size() < 2) begin
                mq.push_back('{pc: m_pc, instr: instr_at(m_pc)});
                m_pc = m_pc + 16'd2;
                m_fetch++;
            end else if (can_fetch) begin
                m_stall++;
            end
            if (m_state == M_IDLE && start) m_state = M_RUN;
            else if (m_state == M_RUN && halt) m_state = M_HALTED;
            else if (m_state == M_HALTED && start && !halt) m_state = M_RUN;
        end
    endtask

    task automatic compare();
        check("imem_pc", {16'h0, imem_pc}, {16'h0, m_pc});
        check("busy", {31'h0, busy}, {31'h0, m_state == M_RUN});
        check("dec_valid", {31'h0, dec_valid}, {31'h0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("dec_pc", {16'h0, dec_pc}, {16'h0, mq[0].pc});
            check("dec_instr", dec_instr, mq[0].instr);
        end
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", {16'h0, fetch_cnt}, (m_fetch > 65535) ? 32'hFFFF : m_fetch);
        check("stall_cnt", {16'h0, stall_cnt}, (m_stall > 65535) ? 32'hFFFF : m_stall);
`endif
    endtask

    task automatic cycle();
        model_next();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_seen(input string name, input int idx, input logic [15:0] pc);
        check({name, "_cnt"}, {31'h0, mseen.size() > idx}, 32'h1);
        if (mseen.size() > idx) check(name, {16'h0, mseen[idx].pc}, {16'h0, pc});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0; dec_ready = 1'b0;
        model_reset();
        #1;
        check("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
        check("rst_imem_pc", {16'h0, imem_pc}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_dec_pc", {16'h0, dec_pc}, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset/start path, then halt/resume at pc 0006
        start = 1'b1; dec_ready = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        check("halt_busy", {31'h0, busy}, 32'h0);
        check("halt_pc", {16'h0, imem_pc}, 32'h0006);
        check_seen("seq0", 0, 16'h0000);
        check_seen("seq1", 1, 16'h0002);
        check_seen("seq2", 2, 16'h0004);
        if (mseen.size() > 2) begin
            check("seq0_instr", mseen[0].instr, 32'hC0DE_1111);
            check("seq1_instr", mseen[1].instr, 32'hC0DC_1113);
            check("seq2_instr", mseen[2].instr, 32'hC0DA_1115);
        end
        repeat (2) cycle();
        check("halted_pc", {16'h0, imem_pc}, 32'h0006);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (2) cycle();
        check_seen("resume", 3, 16'h0006);

        // backpressure from a clean start
        do_reset();
        mseen.delete();
        dec_ready = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        check("bp_pc", {16'h0, imem_pc}, 32'h0004);
        check("bp_count", mq.size(), 32'd2);
`ifdef FETCH_PERF_CNT_EN
        check("bp_stall_cnt", {16'h0, stall_cnt}, 32'd3);
`endif
        dec_ready = 1'b1;
        repeat (3) cycle();
        check_seen("bp0", 0, 16'h0000);
        check_seen("bp1", 1, 16'h0002);
        check_seen("bp2", 2, 16'h0004);

        // redirect while full
        dec_ready = 1'b0;
        repeat (2) cycle();
        redirect = 1'b1; redirect_pc = 16'h0041;
        cycle();
        redirect = 1'b0;
        check("rd_valid", {31'h0, dec_valid}, 32'h0);
        check("rd_pc", {16'h0, imem_pc}, 32'h0040);
        dec_ready = 1'b1;
        cycle();
        check("rd_dec_valid", {31'h0, dec_valid}, 32'h1);
        check("rd_dec_pc", {16'h0, dec_pc}, 32'h0040);

        // wrap
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        cycle();
        redirect = 1'b0;
        mseen.delete();
        repeat (4) cycle();
        check_seen("wrap0", 0, 16'hFFFE);
        check_seen("wrap1", 1, 16'h0000);

        // halt beats start; redirect while halted keeps state
        halt = 1'b1; start = 1'b1;
        cycle();
        halt = 1'b0; start = 1'b0;
        check("halt_wins", {31'h0, busy}, 32'h0);
        redirect = 1'b1; redirect_pc = 16'h0100;
        cycle();
        redirect = 1'b0;
        check("rd_halted_busy", {31'h0, busy}, 32'h0);
        check("rd_halted_pc", {16'h0, imem_pc}, 32'h0100);
        start = 1'b1;
        cycle();
        start = 1'b0;

        // async reset with a full queue
        dec_ready = 1'b0;
        repeat (4) cycle();
        check("pre_ar_valid", {31'h0, dec_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'h0, dec_valid}, 32'h0);
        check("ar_pc", {16'h0, imem_pc}, 32'h0000);
        check("ar_busy", {31'h0, busy}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
        mseen.delete();
        start = 1'b1; dec_ready = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        check_seen("ar_first", 0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
